// File: rtl/kernel_accumulator_if.sv
// Handshake bundle between the kernel array, the accumulator and the output buffer.
// Signal names are taken from the accumulator's point of view.
`ifndef NBIT
`define NBIT 8
`endif
`ifndef NDATA
`define NDATA 4
`endif

interface kernel_accumulator_if #(
  parameter int NBIT  = `NBIT,
  parameter int NDATA = `NDATA,
  parameter int ACCW  = 24,
  parameter int CW    = 8
);
  logic                  i_valid;
  logic                  o_ready;
  logic [NBIT*NDATA-1:0] i_r;
  logic                  i_last;
  logic                  o_valid;
  logic                  i_ready;
  logic [ACCW-1:0]       o_sum;
  logic [CW-1:0]         o_cnt;
  logic                  o_sat;

  modport slave (
    input  i_valid, i_r, i_last, i_ready,
    output o_ready, o_valid, o_sum, o_cnt, o_sat
  );

  modport master (
    output i_valid, i_r, i_last, i_ready,
    input  o_ready, o_valid, o_sum, o_cnt, o_sat
  );
endinterface

// File: rtl/kernel_accumulator.sv
// AdderNet output stage: reduces each beat of |x-w| terms, accumulates beats up to
// the last one and emits the saturated negated L1 distance.
`ifndef NBIT
`define NBIT 8
`endif
`ifndef NDATA
`define NDATA 4
`endif

module kernel_accumulator #(
  parameter int NBIT  = `NBIT,
  parameter int NDATA = `NDATA,
  parameter int ACCW  = 24,
  parameter int CW    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  kernel_accumulator_if.slave   io_bus
);
  localparam int SW = NBIT + $clog2(NDATA);
  localparam int EW = ((ACCW > SW) ? ACCW : SW) + 1;
  localparam logic [EW-1:0] MAXMAG = {{(EW-1){1'b0}}, 1'b1} << (ACCW - 1);

  logic            w_stall;
  logic            w_accept;
  logic [SW-1:0]   w_tree;
  logic [EW-1:0]   w_sum;
  logic            w_over;
  logic [ACCW-1:0] w_mag_next;
  logic            w_sat_next;
  logic [CW-1:0]   w_cnt_next;

  logic            r_a_valid;
  logic            r_a_last;
  logic [SW-1:0]   r_a_sum;
  logic [ACCW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_sat_acc;
  logic            r_valid;
  logic [ACCW-1:0] r_sum;
  logic [CW-1:0]   r_cnt_o;
  logic            r_sat_o;

  // Stall gates every register, so the whole pipeline freezes while a result is held.
  assign w_stall        = r_valid && !io_bus.i_ready;
  assign w_accept       = io_bus.i_valid && !w_stall;
  assign io_bus.o_ready = !w_stall;
  assign io_bus.o_valid = r_valid;
  assign io_bus.o_sum   = r_sum;
  assign io_bus.o_cnt   = r_cnt_o;
  assign io_bus.o_sat   = r_sat_o;

  // Full-width reduction of the terms of one beat.
  always_comb begin
    w_tree = {SW{1'b0}};
    for (int k = 0; k < NDATA; k++) begin
      w_tree = w_tree + SW'(io_bus.i_r[NBIT*k +: NBIT]);
    end
  end

  // Accumulator next values; the magnitude clamps at 2^(ACCW-1).
  always_comb begin
    w_sum      = EW'(r_acc) + EW'(r_a_sum);
    w_over     = (w_sum > MAXMAG);
    w_sat_next = r_sat_acc | w_over;
    if (w_over) begin
      w_mag_next = MAXMAG[ACCW-1:0];
    end else begin
      w_mag_next = w_sum[ACCW-1:0];
    end
    if (r_cnt == {CW{1'b1}}) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Stage A: registered tree sum with its valid and last flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a_valid <= 1'b0;
      r_a_last  <= 1'b0;
      r_a_sum   <= {SW{1'b0}};
    end else if (!w_stall) begin
      r_a_valid <= w_accept;
      r_a_last  <= w_accept & io_bus.i_last;
      r_a_sum   <= w_tree;
    end
  end

  // Stage B: accumulate, and on a last beat hand the result over and restart.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc     <= {ACCW{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_sat_acc <= 1'b0;
      r_valid   <= 1'b0;
      r_sum     <= {ACCW{1'b0}};
      r_cnt_o   <= {CW{1'b0}};
      r_sat_o   <= 1'b0;
    end else if (!w_stall) begin
      if (r_a_valid && r_a_last) begin
        r_acc     <= {ACCW{1'b0}};
        r_cnt     <= {CW{1'b0}};
        r_sat_acc <= 1'b0;
        r_sum     <= {ACCW{1'b0}} - w_mag_next;
        r_cnt_o   <= w_cnt_next;
        r_sat_o   <= w_sat_next;
      end else if (r_a_valid) begin
        r_acc     <= w_mag_next;
        r_cnt     <= w_cnt_next;
        r_sat_acc <= w_sat_next;
      end
      r_valid <= r_a_valid & r_a_last;
    end
  end
endmodule

// File: tb/tb_kernel_accumulator.sv
// Directed bench for kernel_accumulator (NBIT=8, NDATA=4, ACCW=16, CW=8) with
// hand-computed golden results.
module tb_kernel_accumulator;
  localparam int NBIT  = 8;
  localparam int NDATA = 4;
  localparam int ACCW  = 16;
  localparam int CW    = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   run_len;
  int   max_run;

  logic [ACCW-1:0] q_sum[$];
  logic [CW-1:0]   q_cnt[$];
  logic            q_sat[$];

  kernel_accumulator_if #(.NBIT(NBIT), .NDATA(NDATA), .ACCW(ACCW), .CW(CW)) bus ();

  kernel_accumulator #(.NBIT(NBIT), .NDATA(NDATA), .ACCW(ACCW), .CW(CW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every completed output transfer; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!rst && bus.o_valid) begin
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
      if (bus.i_ready) begin
        q_sum.push_back(bus.o_sum);
        q_cnt.push_back(bus.o_cnt);
        q_sat.push_back(bus.o_sat);
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted, bounded to 20 cycles.
  task automatic send(input logic [7:0] val, input logic last);
    int n;
    bus.i_valid = 1'b1;
    bus.i_r     = {NDATA{val}};
    bus.i_last  = last;
    n = 0;
    while (!bus.o_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("send_timeout", 32'd0, 32'd1);
    tick();
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    repeat (6) tick();
  endtask

  task automatic clear_q();
    q_sum.delete();
    q_cnt.delete();
    q_sat.delete();
  endtask

  task automatic expect_res(input string tag, input logic [ACCW-1:0] s,
                            input logic [CW-1:0] c, input logic sa);
    if (q_sum.size() == 0) begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_sum"}, 32'(q_sum.pop_front()), 32'(s));
      check({tag, "_cnt"}, 32'(q_cnt.pop_front()), 32'(c));
      check({tag, "_sat"}, 32'(q_sat.pop_front()), 32'(sa));
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    run_len     = 0;
    max_run     = 0;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_r     = '0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_sum",   32'(bus.o_sum),   32'd0);
    check("rst_cnt",   32'(bus.o_cnt),   32'd0);
    check("rst_sat",   32'(bus.o_sat),   32'd0);
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Single beat of 1s: result after the second edge from presentation.
    bus.i_valid = 1'b1;
    bus.i_r     = {NDATA{8'd1}};
    bus.i_last  = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    check("single_lat1", 32'(bus.o_valid), 32'd0);
    tick();
    check("single_valid", 32'(bus.o_valid), 32'd1);
    check("single_sum",   32'(bus.o_sum),   32'h0000FFFC);
    check("single_cnt",   32'(bus.o_cnt),   32'd1);
    check("single_sat",   32'(bus.o_sat),   32'd0);
    tick();
    check("single_drop", 32'(bus.o_valid), 32'd0);
    drain();
    clear_q();

    // Three beats of 255s.
    send(8'd255, 1'b0);
    send(8'd255, 1'b0);
    send(8'd255, 1'b1);
    drain();
    check("three_pulses", 32'(q_sum.size()), 32'd1);
    expect_res("three", 16'hF40C, 8'd3, 1'b0);
    clear_q();

    // Saturation then a fresh unsaturated result.
    for (int i = 0; i < 33; i++) send(8'd255, (i == 32) ? 1'b1 : 1'b0);
    send(8'd1, 1'b1);
    drain();
    check("sat_count", 32'(q_sum.size()), 32'd2);
    expect_res("sat", 16'h8000, 8'd33, 1'b1);
    expect_res("post_sat", 16'hFFFC, 8'd1, 1'b0);
    clear_q();

    // Backpressure with i_valid held high.
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_r     = {NDATA{8'd2}};
    bus.i_last  = 1'b1;
    tick();
    bus.i_r     = {NDATA{8'd3}};
    tick();
    bus.i_r     = {NDATA{8'd4}};
    bus.i_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready", 32'(bus.o_ready), 32'd0);
      check("bp_valid", 32'(bus.o_valid), 32'd1);
      check("bp_sum",   32'(bus.o_sum),   32'h0000FFF8);
    end
    bus.i_ready = 1'b1;
    tick();
    bus.i_last  = 1'b1;
    tick();
    drain();
    check("bp_count", 32'(q_sum.size()), 32'd3);
    expect_res("bp_a",  16'hFFF8, 8'd1, 1'b0);
    expect_res("bp_b",  16'hFFF4, 8'd1, 1'b0);
    expect_res("bp_cd", 16'hFFE0, 8'd2, 1'b0);
    clear_q();

    // Reset in the middle of a result discards the partial sum.
    send(8'd10, 1'b0);
    send(8'd10, 1'b0);
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(bus.o_valid), 32'd0);
    check("mrst_sum",   32'(bus.o_sum),   32'd0);
    check("mrst_cnt",   32'(bus.o_cnt),   32'd0);
    check("mrst_ready", 32'(bus.o_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    clear_q();
    send(8'd2, 1'b1);
    drain();
    check("mrst_count", 32'(q_sum.size()), 32'd1);
    expect_res("mrst", 16'hFFF8, 8'd1, 1'b0);
    clear_q();

    // Back-to-back single-beat results.
    max_run = 0;
    send(8'd1, 1'b1);
    send(8'd2, 1'b1);
    send(8'd3, 1'b1);
    drain();
    check("b2b_run",   32'(max_run),      32'd3);
    check("b2b_count", 32'(q_sum.size()), 32'd3);
    expect_res("b2b_1", 16'hFFFC, 8'd1, 1'b0);
    expect_res("b2b_2", 16'hFFF8, 8'd1, 1'b0);
    expect_res("b2b_3", 16'hFFF4, 8'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
